safety_mem_responder: RTL
=========================

Name: safety_mem_responder

Overview:
- Responder (subordinate) end of the core's req/gnt/rvalid memory protocol; serves the safety core's instruction or data port from a local SRAM macro.
- Accepts in-order requests, arbitrates for the SRAM through an SRAM grant, and returns each response a fixed SramLatency cycles after acceptance.
- Out-of-range accesses get an error response without touching the SRAM.
- Sits between the core wrapper's memory ports and the safety island's tightly-coupled SRAM banks.

Parameters:
- BaseAddr, 32'h0000_0000, byte base address of the served region
- MemSizeBytes, 65536, region size in bytes; power of two, at least 4
- SramLatency, 1, SRAM read latency in cycles; at least 1
- MaxOutstanding, 2, maximum accepted-but-unanswered requests; at least 1
- SramAddrWidth, $clog2(MemSizeBytes)-2, SRAM word address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  core request valid
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, single-cycle pulse, no back-pressure
- rdata_o  out  32  read data
- err_o  out  1  error response, qualified by rvalid_o
- sram_req_o  out  1  SRAM access request
- sram_gnt_i  in  1  SRAM arbiter grant, may be low because of other masters
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  4  SRAM byte enables
- sram_addr_o  out  SramAddrWidth  SRAM word address, equal to (addr_i-BaseAddr)>>2
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid SramLatency cycles after a granted read

Behaviour:
- Clock and reset: one clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset state: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, sram_req_o=0. The outstanding counter and response pipeline are cleared.
  - Reset asserted mid-operation drops all in-flight responses.
  - No rvalid_o is emitted for pre-reset requests after reset releases.
- in_range: BaseAddr <= addr_i < BaseAddr+MemSizeBytes. The subtraction is 32-bit unsigned; no wrap-around is allowed past 2^32.
- credit: (cnt < MaxOutstanding) | rvalid_o. A response completing this cycle frees its slot in the same cycle.
- sram_req_o = req_i & in_range & credit. The sram_* payload passes through combinationally from the inputs.
- gnt_o = req_i & credit & (in_range ? sram_gnt_i : 1). This is combinational; gnt_o is never asserted without req_i.
- Acceptance happens at cycle T when req_i & gnt_o.
- Response pipeline: an SramLatency-deep shift register of {valid, err, is_read}, loaded at acceptance.
  - rvalid_o is asserted at exactly T+SramLatency, and only for that one cycle.
  - Responses come back in acceptance order. Back-to-back accepts give back-to-back rvalid_o.
- Response data:
  - In-range read: rdata_o = sram_rdata_i in the rvalid_o cycle, err_o=0.
  - In-range write: rdata_o=0, err_o=0.
  - Out-of-range access (read or write): rdata_o=0, err_o=1. No SRAM access is made.
- be_i=0 on a write: sram_req_o is still issued, so no bytes change; the response is a normal write response.
- Outstanding counter cnt, range 0..MaxOutstanding:
  - +1 on accept; -1 on rvalid_o; unchanged when both happen in the same cycle.
  - It must never overflow or underflow; an assertion checks this.
  - If MaxOutstanding < SramLatency, throughput drops to MaxOutstanding per SramLatency cycles.
- While req_i=1 and gnt_o=0, the core holds its payload stable. The block keeps no state about the stalled request.
- Simultaneous cases:
  - Accept and response in the same cycle when cnt==MaxOutstanding: accepted.
  - sram_gnt_i low with an out-of-range request: still granted.

Test Plan:
- Single read: preload word 0x40 with 0xDEAD_BEEF; read BaseAddr+0x40 accepted at T -> rvalid_o at T+SramLatency, rdata_o=0xDEAD_BEEF, err_o=0.
- Write then read: write 0x1234_5678 with be_i=4'b0011 to word 0x10 (old value 0xFFFF_FFFF) -> write response err_o=0, rdata_o=0; a following read returns 0xFFFF_5678.
- Out of range: read at BaseAddr+MemSizeBytes with sram_gnt_i=0 -> gnt_o=1 and sram_req_o=0 in the same cycle; rvalid_o after SramLatency cycles with err_o=1, rdata_o=0.
- Credit limit: SramLatency=3, MaxOutstanding=2, req_i held high -> exactly 2 grants per 3 cycles; cnt never exceeds 2; responses stay in order.
- SRAM arbitration: sram_gnt_i=0 for 5 cycles under an in-range req_i -> gnt_o=0 for 5 cycles and no rvalid_o; grant follows in the cycle sram_gnt_i rises.
- Reset mid-flight: two reads accepted, rst_ni pulsed low before any response -> no rvalid_o after release, cnt=0, and the next request is granted immediately.

Source files
------------

// File: rtl/safety_mem_responder.sv
// Purpose: subordinate end of the core req/gnt/rvalid memory protocol, serving one port from a local SRAM.
// Latency: response (rvalid_o) exactly SramLatency cycles after acceptance; gnt_o is combinational.
// Backpressure: stalls via gnt_o=0 when out of credit or when the SRAM arbiter withholds its grant.
module safety_mem_responder #(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned MemSizeBytes   = 65536,
  parameter int unsigned SramLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SramAddrWidth  = $clog2(MemSizeBytes) - 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [31:0]              addr_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              wdata_i,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     sram_req_o,
  input  logic                     sram_gnt_i,
  output logic                     sram_we_o,
  output logic [3:0]               sram_be_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [31:0]              sram_wdata_o,
  input  logic [31:0]              sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  // One slot of the response pipeline: what the response must look like when it emerges.
  typedef struct packed {
    logic vld;
    logic err;
    logic rd;
  } resp_t;

  resp_t [SramLatency-1:0] pipe_q, pipe_d;
  logic  [CntWidth-1:0]    cnt_q, cnt_d;

  logic [31:0] offset;
  logic        in_range;
  logic        credit;
  logic        accept;
  resp_t       resp_out;

  // Region offset; checking addr_i >= BaseAddr first keeps the subtraction from wrapping.
  assign offset   = addr_i - BaseAddr;
  assign in_range = (addr_i >= BaseAddr) && (offset < MemSizeBytes);

  // A response leaving this cycle frees its slot immediately, so a full pipe can still accept.
  assign credit = (cnt_q < CntMax) | rvalid_o;

  // Out-of-range requests never reach the SRAM, so they do not wait for its grant.
  assign sram_req_o = req_i & in_range & credit;
  assign gnt_o      = req_i & credit & (in_range ? sram_gnt_i : 1'b1);
  assign accept     = req_i & gnt_o;

  // SRAM payload is a straight pass-through of the core request.
  assign sram_we_o    = we_i;
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;
  assign sram_addr_o  = offset[SramAddrWidth+1:2];

  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:SramAddrWidth+2], offset[1:0]};

  // Response formatting: only in-range reads carry SRAM data, errors always return zero data.
  assign resp_out = pipe_q[SramLatency-1];
  assign rvalid_o = resp_out.vld;
  assign err_o    = resp_out.vld & resp_out.err;
  assign rdata_o  = (resp_out.vld & resp_out.rd & ~resp_out.err) ? sram_rdata_i : 32'h0;

  // Next state of the response shift register and the outstanding counter.
  always_comb begin
    pipe_d        = pipe_q;
    pipe_d[0].vld = accept;
    pipe_d[0].err = ~in_range;
    pipe_d[0].rd  = ~we_i;
    for (int i = 1; i < SramLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    cnt_d = cnt_q;
    case ({accept, rvalid_o})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards every in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  cnt_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(accept && !rvalid_o && (cnt_q == CntMax)));
  cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_o && !accept && (cnt_q == '0)));
`endif

endmodule
